// File: rtl/lw_digest_out_if.sv
// Word-stream handshake bundle for lw_digest_out: the digest source drives the master side.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

interface lw_digest_out_if #(
    parameter int DATA_W = `WORD_SIZE
);
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] out_data_o;
    logic              out_last_o;

    modport master (output out_valid_o, out_data_o, out_last_o, input out_ready_i);
    modport slave  (input out_valid_o, out_data_o, out_last_o, output out_ready_i);
endinterface

// File: rtl/lw_digest_out.sv
// Captures a finished digest on a done_i rising edge and streams it word by word (index 7 first).
// Optional macro DIGEST_CMP_EN adds a constant-time tag comparison mode (state CMP).
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module lw_digest_out #(
    parameter int DATA_W = `WORD_SIZE
) (
    input  logic              clk_i,
    input  logic              aresetn_i,
    input  logic              done_i,
    input  logic [DATA_W-1:0] hash_i [7:0],
    input  logic [3:0]        len_i,
    input  logic              abort_i,
    lw_digest_out_if.master   out_if,
    output logic              busy_o,
    output logic              overrun_o
`ifdef DIGEST_CMP_EN
    ,
    input  logic              cmp_i,
    input  logic [DATA_W-1:0] tag_i,
    input  logic              tag_valid_i,
    output logic              tag_ready_o,
    output logic              match_o,
    output logic              match_valid_o
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_CMP  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              done_prev_q;
    logic [DATA_W-1:0] buf_q [7:0];
    logic [DATA_W-1:0] buf_d [7:0];
    logic [3:0]        cnt_q, cnt_d;
    logic              overrun_q, overrun_d;
    logic              done_rise;

`ifdef DIGEST_CMP_EN
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              match_q, match_d;
    logic              match_valid_q, match_valid_d;
`endif

    // Lengths of 0 or above 8 select the full 8-word digest.
    function automatic logic [3:0] eff_len(input logic [3:0] l);
        return (l == 4'd0 || l > 4'd8) ? 4'd8 : l;
    endfunction

    assign done_rise = done_i & ~done_prev_q;

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        overrun_d = done_rise && (state_q != ST_IDLE);
`ifdef DIGEST_CMP_EN
        acc_d         = acc_q;
        match_d       = match_q;
        match_valid_d = 1'b0;
`endif
        if (abort_i) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
            for (int i = 0; i < 8; i++) buf_d[i] = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (done_rise) begin
                        buf_d   = hash_i;
                        cnt_d   = eff_len(len_i);
                        state_d = ST_SEND;
`ifdef DIGEST_CMP_EN
                        acc_d   = '0;
                        match_d = 1'b0;
                        if (cmp_i) state_d = ST_CMP;
`endif
                    end
                end
                ST_SEND: begin
                    if (out_if.out_ready_i) begin
                        for (int i = 7; i > 0; i--) buf_d[i] = buf_q[i-1];
                        buf_d[0] = '0;
                        cnt_d    = cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_d = ST_IDLE;
                            for (int i = 0; i < 8; i++) buf_d[i] = '0;
                        end
                    end
                end
`ifdef DIGEST_CMP_EN
                ST_CMP: begin
                    // Every tag word is folded in; a mismatch never shortens the walk.
                    if (tag_valid_i) begin
                        acc_d = acc_q | (buf_q[7] ^ tag_i);
                        for (int i = 7; i > 0; i--) buf_d[i] = buf_q[i-1];
                        buf_d[0] = '0;
                        cnt_d    = cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            match_d       = (acc_d == '0);
                            match_valid_d = 1'b1;
                            state_d       = ST_IDLE;
                            for (int i = 0; i < 8; i++) buf_d[i] = '0;
                        end
                    end
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                    for (int i = 0; i < 8; i++) buf_d[i] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_q     <= ST_IDLE;
            done_prev_q <= 1'b0;
            cnt_q       <= 4'd0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < 8; i++) buf_q[i] <= '0;
`ifdef DIGEST_CMP_EN
            acc_q         <= '0;
            match_q       <= 1'b0;
            match_valid_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            done_prev_q <= done_i;
            cnt_q       <= cnt_d;
            overrun_q   <= overrun_d;
            buf_q       <= buf_d;
`ifdef DIGEST_CMP_EN
            acc_q         <= acc_d;
            match_q       <= match_d;
            match_valid_q <= match_valid_d;
`endif
        end
    end

    assign out_if.out_valid_o = (state_q == ST_SEND);
    assign out_if.out_data_o  = (state_q == ST_SEND) ? buf_q[7] : '0;
    assign out_if.out_last_o  = (state_q == ST_SEND) && (cnt_q == 4'd1);
    assign busy_o             = (state_q != ST_IDLE);
    assign overrun_o          = overrun_q;

`ifdef DIGEST_CMP_EN
    assign tag_ready_o   = (state_q == ST_CMP);
    assign match_o       = match_q;
    assign match_valid_o = match_valid_q;
`endif

endmodule

// File: tb/tb_lw_digest_out.sv
// Scoreboard bench for lw_digest_out: expected words are queued at capture and popped on each transfer.
`timescale 1ns/1ps

module tb_lw_digest_out;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        done;
    logic [31:0] hash [7:0];
    logic [3:0]  len;
    logic        abort;
    logic        busy;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int xfers  = 0;

    logic [32:0] exp_q [$];
    logic        stall_pend = 1'b0;
    logic [31:0] stall_data;

    lw_digest_out_if #(.DATA_W(32)) bus ();

`ifdef DIGEST_CMP_EN
    logic        cmp;
    logic [31:0] tag;
    logic        tag_valid;
    logic        tag_ready;
    logic        match;
    logic        match_valid;
`endif

    lw_digest_out #(.DATA_W(32)) dut (
        .clk_i     (clk),
        .aresetn_i (aresetn),
        .done_i    (done),
        .hash_i    (hash),
        .len_i     (len),
        .abort_i   (abort),
        .out_if    (bus),
        .busy_o    (busy),
        .overrun_o (overrun)
`ifdef DIGEST_CMP_EN
        ,
        .cmp_i         (cmp),
        .tag_i         (tag),
        .tag_valid_i   (tag_valid),
        .tag_ready_o   (tag_ready),
        .match_o       (match),
        .match_valid_o (match_valid)
`endif
    );

    always #5 clk = ~clk;

    // Output monitor: transfers pop the scoreboard, stalls must hold, idle data must be zero.
    always @(negedge clk) begin
        if (stall_pend) begin
            checks++;
            if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== stall_data) begin
                errors++;
                $display("FAIL stall_hold valid=%b data=%h required valid=1 data=%h",
                         bus.out_valid_o, bus.out_data_o, stall_data);
            end
        end
        stall_pend = 1'b0;
        if (bus.out_valid_o !== 1'b1) begin
            checks++;
            if (bus.out_data_o !== 32'h0 || bus.out_last_o !== 1'b0) begin
                errors++;
                $display("FAIL idle_outputs data=%h last=%b required 0/0", bus.out_data_o, bus.out_last_o);
            end
        end else if (bus.out_ready_i === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word data=%h required no transfer", bus.out_data_o);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                if ({bus.out_last_o, bus.out_data_o} !== e) begin
                    errors++;
                    $display("FAIL word last=%b data=%h required last=%b data=%h",
                             bus.out_last_o, bus.out_data_o, e[32], e[31:0]);
                end
            end
            xfers++;
        end else begin
            stall_pend = 1'b1;
            stall_data = bus.out_data_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise done_i with the given length, queue the expected stream and check first-word latency.
    task automatic start_digest(input logic [3:0] l, input bit keep_done);
        int eff;
        eff  = (l == 0 || l > 8) ? 8 : int'(l);
        len  = l;
        done = 1'b1;
        for (int k = 0; k < eff; k++) exp_q.push_back({(k == eff - 1), hash[7-k]});
        tick();
        checks++;
        if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== hash[7] || busy !== 1'b1) begin
            errors++;
            $display("FAIL latency valid=%b data=%h busy=%b required 1/%h/1",
                     bus.out_valid_o, bus.out_data_o, busy, hash[7]);
        end
        if (!keep_done) done = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_finish busy=%b pending=%0d required busy=0 pending=0", name, busy, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        #2;
        checks++;
        if (bus.out_valid_o !== 1'b0 || bus.out_data_o !== 32'h0 || bus.out_last_o !== 1'b0 ||
            busy !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs valid=%b data=%h last=%b busy=%b ovr=%b required all 0",
                     bus.out_valid_o, bus.out_data_o, bus.out_last_o, busy, overrun);
        end
        tick();
        tick();
        aresetn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int n = 0;
        int x0;
        bus.out_ready_i = 1'b1;
        x0 = xfers;
        start_digest(4'd8, 1'b0);
        while (bus.out_valid_o === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        checks++;
        if (n != 8 || busy !== 1'b0 || xfers - x0 != 8) begin
            errors++;
            $display("FAIL basic_stream valid_cycles=%0d xfers=%0d busy=%b required 8/8/0", n, xfers - x0, busy);
        end
        wait_idle("basic", 4);
    endtask

    task automatic test_stall();
        int n = 0;
        int x0;
        bus.out_ready_i = 1'b1;
        x0 = xfers;
        start_digest(4'd7, 1'b0);
        while (busy === 1'b1 && n < 40) begin
            bus.out_ready_i = ~bus.out_ready_i;
            tick();
            n++;
        end
        bus.out_ready_i = 1'b1;
        checks++;
        if (xfers - x0 != 7) begin
            errors++;
            $display("FAIL stall_count xfers=%0d required 7", xfers - x0);
        end
        wait_idle("stall", 4);
    endtask

    task automatic test_len_clamp();
        logic [3:0] lens [3];
        int x0;
        lens[0] = 4'd0;
        lens[1] = 4'd12;
        lens[2] = 4'd1;
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            x0 = xfers;
            start_digest(lens[i], 1'b0);
            wait_idle("len_clamp", 20);
            checks++;
            if (xfers - x0 != ((lens[i] == 4'd1) ? 1 : 8)) begin
                errors++;
                $display("FAIL len_clamp len=%0d xfers=%0d required %0d",
                         lens[i], xfers - x0, (lens[i] == 4'd1) ? 1 : 8);
            end
            tick();
        end
    endtask

    task automatic test_overrun();
        int pulses = 0;
        int n = 0;
        bus.out_ready_i = 1'b1;
        start_digest(4'd8, 1'b0);
        tick();
        tick();
        done = 1'b1;
        while (busy === 1'b1 && n < 20) begin
            tick();
            if (overrun === 1'b1) pulses++;
            n++;
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (overrun === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL overrun_pulses got=%0d required 1", pulses);
        end
        checks++;
        if (busy !== 1'b0 || bus.out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL done_held_retrigger busy=%b valid=%b required 0/0", busy, bus.out_valid_o);
        end
        wait_idle("overrun", 2);
        done = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        bus.out_ready_i = 1'b1;
        start_digest(4'd8, 1'b0);
        tick();
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (bus.out_valid_o !== 1'b0 || bus.out_data_o !== 32'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_stop valid=%b data=%h busy=%b required 0/0/0", bus.out_valid_o, bus.out_data_o, busy);
        end
        exp_q.delete();
        done  = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || bus.out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_discard_edge busy=%b valid=%b required 0/0", busy, bus.out_valid_o);
        end
        done = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        bus.out_ready_i = 1'b1;
        start_digest(4'd8, 1'b0);
        tick();
        aresetn = 1'b0;
        #1;
        checks++;
        if (bus.out_valid_o !== 1'b0 || bus.out_data_o !== 32'h0 || bus.out_last_o !== 1'b0 ||
            busy !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid valid=%b data=%h last=%b busy=%b ovr=%b required all 0",
                     bus.out_valid_o, bus.out_data_o, bus.out_last_o, busy, overrun);
        end
        exp_q.delete();
        #10;
        aresetn = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || bus.out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_resume busy=%b valid=%b required 0/0", busy, bus.out_valid_o);
        end
    endtask

`ifdef DIGEST_CMP_EN
    task automatic test_compare(input bit flip);
        logic [31:0] tagv [8];
        for (int k = 0; k < 8; k++) tagv[k] = hash[7-k];
        if (flip) tagv[0] = tagv[0] ^ 32'h1;
        cmp       = 1'b1;
        tag_valid = 1'b1;
        len       = 4'd8;
        done      = 1'b1;
        tick();
        done = 1'b0;
        cmp  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (tag_ready !== 1'b1 || match_valid !== 1'b0 || bus.out_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL cmp_walk k=%0d ready=%b mvalid=%b valid=%b required 1/0/0",
                         k, tag_ready, match_valid, bus.out_valid_o);
            end
            tag = tagv[k];
            tick();
        end
        checks++;
        if (match_valid !== 1'b1 || match !== !flip || busy !== 1'b0) begin
            errors++;
            $display("FAIL cmp_result mvalid=%b match=%b busy=%b required 1/%b/0", match_valid, match, busy, !flip);
        end
        tick();
        checks++;
        if (match_valid !== 1'b0 || match !== !flip) begin
            errors++;
            $display("FAIL cmp_hold mvalid=%b match=%b required 0/%b", match_valid, match, !flip);
        end
        tag_valid = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        done            = 1'b0;
        len             = 4'd8;
        abort           = 1'b0;
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) hash[i] = 32'h11111111 * (8 - i);
`ifdef DIGEST_CMP_EN
        cmp       = 1'b0;
        tag       = 32'h0;
        tag_valid = 1'b0;
`endif
        test_reset();
        test_basic();
        test_stall();
        test_len_clamp();
        test_overrun();
        test_abort();
        test_reset_mid();
`ifdef DIGEST_CMP_EN
        test_compare(1'b0);
        test_compare(1'b1);
`endif
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lw_digest_out.md
LW_DIGEST_OUT -- requirements
Module: lw_digest_out

Interface
REQ-001 clk_i  input  1  core clock; all state on rising edge.
REQ-002 aresetn_i  input  1  reset, asynchronous, active-low.
REQ-003 done_i  input  1  digest-available level from the hash/HMAC core; held high until that core restarts.
REQ-004 hash_i  input  `WORD_SIZE x 8 (unpacked [7:0])  digest words; index 7 is the first word in digest order.
REQ-005 len_i  input  4  number of words to emit, 1..8; value 0 or >8 SHALL mean 8; sampled at capture.
REQ-006 abort_i  input  1  synchronous abort, highest priority.
REQ-007 out_valid_o / out_ready_i  output / input  1 / 1  word-stream handshake; transfer when both high.
REQ-008 out_data_o  output  `WORD_SIZE  current digest word.
REQ-009 out_last_o  output  1  high with the final word of a digest.
REQ-010 busy_o  output  1  high whenever the state is not IDLE.
REQ-011 overrun_o  output  1  one-cycle pulse: new digest edge arrived while busy.

Function
REQ-012 States SHALL be IDLE, SEND, and (with DIGEST_CMP_EN) CMP; 2-bit encoding; undefined codes -> IDLE.
REQ-013 Capture: in IDLE, a rising edge of done_i (done_i high, registered previous value low) SHALL load all 8 hash_i words into an internal buffer, latch len_i into remaining count, and enter SEND (or CMP).
REQ-014 Latency: out_valid_o SHALL be high in the cycle after done_i is first sampled high; out_data_o = hash_i[7] captured value.
REQ-015 out_data_o and out_valid_o SHALL be stable while out_valid_o && !out_ready_i.
REQ-016 Each accepted transfer SHALL advance to the next lower index (7,6,...); emitted words = effective length only.
REQ-017 out_last_o SHALL be high exactly when the remaining count equals 1 and out_valid_o is high.
REQ-018 Accepting the last word SHALL return to IDLE next cycle; out_valid_o low that cycle; back-to-back digests need a fresh done_i rising edge.
REQ-019 Buffer SHALL be zeroed on completion, on abort, and on reset; out_data_o SHALL read 0 whenever out_valid_o is low.
REQ-020 A done_i rising edge while busy SHALL be ignored (buffer unchanged) and pulse overrun_o for one cycle.
REQ-021 done_i held high continuously SHALL NOT re-trigger capture after returning to IDLE.
REQ-022 abort_i high SHALL force IDLE next cycle, drop out_valid_o, and discard a same-cycle done_i edge; edge detector still updates.

Reset
REQ-023 On aresetn_i low: state IDLE, buffer 0, count 0, done_i history 0, all outputs 0 (match outputs included).
REQ-024 Reset mid-transfer SHALL drop out_valid_o immediately (asynchronous) with no partial completion.

Configuration
REQ-025 Macro DIGEST_CMP_EN: when defined, adds ports cmp_i (in,1, sampled at capture), tag_i (in,`WORD_SIZE), tag_valid_i (in,1), tag_ready_o (out,1), match_o (out,1), match_valid_o (out,1).
REQ-026 With DIGEST_CMP_EN and cmp_i=1 at capture, state CMP SHALL consume len tag words (tag_ready_o high in CMP), OR-accumulate word XOR differences, keep out_valid_o low.
REQ-027 Compare SHALL be constant-time: no early exit on mismatch; after the last tag word, match_valid_o pulses one cycle with match_o = (accumulator==0), held until next capture; then IDLE.
REQ-028 Without DIGEST_CMP_EN: those ports absent, CMP state absent, all captures go to SEND.

Verification (WORD_SIZE=32)
REQ-029 hash_i[7..0]=0x11111111..0x88888888, len 8, done_i rise, out_ready_i=1 -> valid next cycle, 8 words 0x11111111..0x88888888 consecutive, last on 8th, busy_o low after.
REQ-030 len_i=7, out_ready_i toggling 1/0 -> 7 words, data held during stalls, out_last_o with 0x77777777.
REQ-031 done_i rises again during SEND after word 3 -> overrun_o one pulse, stream unchanged; done_i held high after finish -> no second stream.
REQ-032 abort_i at word 4 -> out_valid_o low next cycle, out_data_o 0, busy_o 0; aresetn_i low mid-stream -> all outputs 0.
REQ-033 DIGEST_CMP_EN, cmp_i=1, len 8, tag equal to digest -> match_valid_o pulse, match_o=1; tag word 0 bit 0 flipped -> match_o=0, match_valid_o after exactly 8 tag transfers.
